serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing diff = a - b, one bit per clock, LSB first. A single full-subtractor cell and a borrow flip-flop process both operands out of shift registers. It is the inverse-operation counterpart of the team's bit-serial adder. A start/busy/done handshake wraps it so a controller can issue operations without tracking cycle counts.

Parameters:
N, 4, operand and result width in bits (N >= 2)

Ports:
CLK  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  N  minuend; captured on the accepted start edge
b  input  N  subtrahend; captured on the accepted start edge
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  one-cycle pulse when the result is valid
diff  output  N  registered difference a - b mod 2^N
borrow_out  output  1  final borrow; 1 when a < b unsigned

Behaviour:
- Reset (rst_n low, async): state=IDLE; operand regs, result reg, borrow FF and bit counter cleared; busy=0, done=0, diff=0, borrow_out=0.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge E0 loads A<=a, B<=b, borrow<=0, count<=0, state<=SHIFT. start=0 keeps IDLE.
- SHIFT: each edge uses x=A[0], y=B[0], bi=borrow:
  - d = x^y^bi
  - bo = (~x&y)|(~x&bi)|(y&bi)
  - A <= {d, A[N-1:1]}; B <= {1'b0, B[N-1:1]}; borrow <= bo; count <= count+1.
  - Bits are processed at edges E1..EN.
  - At EN (count==N-1): diff <= {d, A[N-1:1]}; borrow_out <= bo; state <= DONE.
- DONE: done=1 for exactly this one cycle; next edge state<=IDLE.
- busy=1 iff state==SHIFT, i.e. exactly N cycles. done and busy are never high together.
- Latency: start accepted at E0 -> done high during the cycle after EN -> new start accepted at E(N+2) at the earliest.
- start while SHIFT or DONE: ignored; no queuing; a, b not re-sampled. a and b may change freely after E0.
- diff and borrow_out hold their value from completion until the next completion. They do not change during a subsequent SHIFT.
- Width: all arithmetic is mod 2^N. The counter is ceil(log2(N))+1 bits and saturation cannot occur.
- Reset asserted mid-SHIFT: the operation aborts immediately and all outputs return to reset values. No done pulse.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), registered with diff at EN. ovf = (a[N-1]^b[N-1]) & (diff[N-1]^a[N-1]) using the captured operands (signed overflow). Reset value 0; holds with diff.
- Undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan:
- N=4, a=1001, b=1010, start pulse -> busy high 4 cycles, done pulse 1 cycle later, diff=1111, borrow_out=1 (ovf=0 if enabled).
- a=1010, b=1001 -> diff=0001, borrow_out=0; a=0000, b=0000 -> diff=0000, borrow_out=0.
- a=0111, b=1000 (7 - (-8)) -> diff=1111, borrow_out=1, ovf=1 with SERIAL_SUB_OVF_EN; build without the macro compiles with no ovf port.
- Start held high continuously plus a/b changed during SHIFT -> only one operation per IDLE visit; results match operands captured at acceptance; next start accepted exactly at E(N+2).
- rst_n pulsed low after 2 SHIFT edges -> busy, done, diff, borrow_out immediately 0, no done pulse; a fresh start then completes correctly (a=0101, b=0011 -> diff=0010, borrow_out=0).

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, diff = a - b, LSB first
// Optional signed-overflow output ovf enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int N = 4
) (
   input  logic         CLK,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic         ovf,
`endif
   output logic         borrow_out
);

   localparam int CW = $clog2(N) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]   state;
   logic [N-1:0] a_sr;
   logic [N-1:0] b_sr;
   logic         borrow;
   logic [CW-1:0] count;

   logic x, y, bi, d, bo;

   always_comb begin
      x  = a_sr[0];
      y  = b_sr[0];
      bi = borrow;
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~x & bi) | (y & bi);
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits are shifted out of a_sr/b_sr, so keep copies for the overflow test.
   logic a_msb, b_msb;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            a_msb <= a[N-1];
            b_msb <= b[N-1];
         end
         if (state == SHIFT && count == CW'(N - 1))
            ovf <= (a_msb ^ b_msb) & (d ^ a_msb);
      end
   end
`endif

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         borrow     <= 1'b0;
         count      <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= 1'b0;
                  count  <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               // Result bits refill a_sr from the top as minuend bits drain out the bottom.
               a_sr   <= {d, a_sr[N-1:1]};
               b_sr   <= {1'b0, b_sr[N-1:1]};
               borrow <= bo;
               count  <= count + 1'b1;
               if (count == CW'(N - 1)) begin
                  diff       <= {d, a_sr[N-1:1]};
                  borrow_out <= bo;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed table-driven bench for serial_subtractor (N=4)
module tb_serial_subtractor;

   localparam int N = 4;

   logic         CLK;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_subtractor #(.N(N)) dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf        (ovf),
`endif
      .borrow_out (borrow_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [N-1:0] va;
      logic [N-1:0] vb;
      logic [N-1:0] ed;
      logic         eb;
      logic         eo;
   } vec_t;

   int n_vec;
   int n_err;
   logic [N-1:0] held_diff;
   logic         held_bo;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One complete operation from an idle DUT, checking handshake timing and result hold.
   task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                         input logic [N-1:0] ed, input logic eb, input logic eo);
      int busy_cnt;
      int cyc;
      n_vec++;
      @(negedge CLK);
      a = va; b = vb; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      a = ~va; b = ~vb;
      busy_cnt = 0;
      cyc = 0;
      while (!done && cyc < 20) begin
         if (busy) busy_cnt++;
         chk("diff_hold", diff, held_diff);
         chk("borrow_hold", borrow_out, held_bo);
         @(negedge CLK);
         cyc++;
      end
      chk("done_seen", done, 1'b1);
      chk("busy_cycles", busy_cnt, N);
      chk("busy_with_done", busy, 1'b0);
      chk("diff", diff, ed);
      chk("borrow_out", borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", ovf, eo);
`else
      if (eo !== 1'b0 && eo !== 1'b1) chk("ovf_vec", eo, 1'b0);
`endif
      @(negedge CLK);
      chk("done_one_cycle", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      held_diff = ed;
      held_bo   = eb;
   endtask

   vec_t vecs[8];

   initial begin
      n_vec = 0;
      n_err = 0;
      held_diff = '0;
      held_bo   = 1'b0;
      vecs[0] = '{4'b1001, 4'b1010, 4'b1111, 1'b1, 1'b0};
      vecs[1] = '{4'b1010, 4'b1001, 4'b0001, 1'b0, 1'b0};
      vecs[2] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
      vecs[3] = '{4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1};
      vecs[4] = '{4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0};
      vecs[5] = '{4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0};
      vecs[6] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1};
      vecs[7] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge CLK);
      n_vec++;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_diff", diff, 4'b0000);
      chk("rst_borrow", borrow_out, 1'b0);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].eo);

      // start held high with operands changing: one operation per IDLE visit, next at E(N+2)
      n_vec++;
      @(negedge CLK);
      a = 4'b0011; b = 4'b0001; start = 1'b1;
      for (int k = 0; k < N; k++) begin
         @(negedge CLK);
         a = 4'($urandom); b = 4'($urandom);
         chk("hold_busy", busy, 1'b1);
         chk("hold_done_low", done, 1'b0);
      end
      @(negedge CLK);
      a = 4'b0100; b = 4'b0110;
      chk("hold_done", done, 1'b1);
      chk("hold_busy_low", busy, 1'b0);
      chk("hold_diff", diff, 4'b0010);
      chk("hold_borrow", borrow_out, 1'b0);
      @(negedge CLK);
      chk("hold_idle_busy", busy, 1'b0);
      chk("hold_idle_done", done, 1'b0);
      @(negedge CLK);
      start = 1'b0;
      a = 4'b1111; b = 4'b0000;
      chk("hold_restart", busy, 1'b1);
      repeat (N) @(negedge CLK);
      chk("hold2_done", done, 1'b1);
      chk("hold2_diff", diff, 4'b1110);
      chk("hold2_borrow", borrow_out, 1'b1);
      @(negedge CLK);
      held_diff = 4'b1110;
      held_bo   = 1'b1;

      // reset after two SHIFT edges aborts with no done pulse
      n_vec++;
      @(negedge CLK);
      a = 4'b0110; b = 4'b0001; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (2) @(negedge CLK);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_diff", diff, 4'b0000);
      chk("abort_borrow", borrow_out, 1'b0);
      @(negedge CLK);
      rst_n = 1'b1;
      for (int k = 0; k < N + 2; k++) begin
         @(negedge CLK);
         chk("abort_no_done", done, 1'b0);
         chk("abort_no_busy", busy, 1'b0);
      end
      held_diff = '0;
      held_bo   = 1'b0;
      run_op(4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
